// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the shift_register_n datapath slice.
package shift_reg_pkg;

  typedef enum logic {SHR_RIGHT = 1'b0, SHR_LEFT = 1'b1} shr_dir_t;

  typedef enum logic [1:0] {ACT_HOLD, ACT_CLR, ACT_LOAD, ACT_SHIFT} shr_act_t;

  function automatic int shr_cnt_w(int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_counter.sv
// Saturating shift counter with a registered Done flag that rises on the edge reaching MAX.
module shift_counter
  import shift_reg_pkg::*;
#(
  parameter int MAX   = 8,
  parameter int CNT_W = shr_cnt_w(MAX)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && cnt_q != MAX_C)
      cnt_d = cnt_q + CNT_W'(1);
    // Done follows the next count so it rises together with the final increment.
    done_d = (cnt_d == MAX_C);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = done_q;

endmodule

// File: rtl/shift_register_n.sv
// Parametrised shift register: clear/load/bidirectional logical or arithmetic shift with counter.
// Optional rotate mode (adds Rot port) when SHIFT_REG_ROTATE_EN is defined.
module shift_register_n
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = shr_cnt_w(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clr,
  input  logic             Load,
  input  logic             Shift,
  input  logic             Dir,
  input  logic             Arith,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             Rot,
`endif
  input  logic             Sin,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  output logic             Sout,
  output logic [CNT_W-1:0] ShiftCnt,
  output logic             Done
);

  shr_act_t         act;
  logic [WIDTH-1:0] dout_q, dout_d, shifted;
  logic             sout_q, sout_d;
  logic             left, out_bit, fill;

  always_comb begin
    if (Clr)        act = ACT_CLR;
    else if (Load)  act = ACT_LOAD;
    else if (Shift) act = ACT_SHIFT;
    else            act = ACT_HOLD;
  end

  assign left    = (shr_dir_t'(Dir) == SHR_LEFT);
  assign out_bit = left ? dout_q[WIDTH-1] : dout_q[0];

`ifdef SHIFT_REG_ROTATE_EN
  assign fill = Rot ? out_bit : ((!left && Arith) ? dout_q[WIDTH-1] : Sin);
`else
  assign fill = (!left && Arith) ? dout_q[WIDTH-1] : Sin;
`endif

  // A single-bit register has nothing to slide, so the fill bit is the whole word.
  generate
    if (WIDTH == 1) begin : g_w1
      assign shifted = fill;
    end else begin : g_wn
      assign shifted = left ? {dout_q[WIDTH-2:0], fill} : {fill, dout_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    dout_d = dout_q;
    sout_d = sout_q;
    case (act)
      ACT_CLR:   begin dout_d = '0;      sout_d = 1'b0;    end
      ACT_LOAD:  begin dout_d = Din;     sout_d = 1'b0;    end
      ACT_SHIFT: begin dout_d = shifted; sout_d = out_bit; end
      default:   ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dout_q <= '0;
      sout_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      sout_q <= sout_d;
    end
  end

  shift_counter #(.MAX(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .Clk    (Clk),
    .Reset  (Reset),
    .clr    (act == ACT_CLR || act == ACT_LOAD),
    .inc    (act == ACT_SHIFT),
    .cnt_o  (ShiftCnt),
    .done_o (Done)
  );

  assign Dout = dout_q;
  assign Sout = sout_q;

endmodule
